// File: rtl/bram_capture_buffer_if.sv
// Capture/readback bus for bram_capture_buffer: capture controls, logical read port
// and status. The capture block takes the slave side.
interface bram_capture_buffer_if #(
  parameter int RAM_EXP   = 10,
  parameter int RAM_WIDTH = 32
);
  logic                 i_arm;
  logic                 i_stop;
  logic                 i_valid;
  logic [RAM_WIDTH-1:0] i_data;
  logic                 i_read_enb;
  logic [RAM_EXP-1:0]   i_addr_r;
  logic [RAM_WIDTH-1:0] o_data;
  logic                 o_data_valid;
  logic                 o_busy;
  logic                 o_done;
  logic [RAM_EXP:0]     o_count;
  logic [RAM_EXP-1:0]   o_wr_ptr;

  modport master (
    output i_arm, i_stop, i_valid, i_data, i_read_enb, i_addr_r,
    input  o_data, o_data_valid, o_busy, o_done, o_count, o_wr_ptr
  );

  modport slave (
    input  i_arm, i_stop, i_valid, i_data, i_read_enb, i_addr_r,
    output o_data, o_data_valid, o_busy, o_done, o_count, o_wr_ptr
  );
endinterface

// File: rtl/bram_capture_buffer.sv
// Block-RAM sample capture buffer (one-shot or circular) with oldest-first readback.
// Define BRAM_CAPTURE_OUT_REG_EN to add an output register (read latency 2 instead of 1).
module bram_capture_buffer #(
  parameter int RAM_EXP   = 10,
  parameter int RAM_WIDTH = 32,
  parameter int CIRCULAR  = 0
) (
  input  logic                  clk,
  input  logic                  i_rst,
  bram_capture_buffer_if.slave  bus
);
  localparam int               DEPTH = 1 << RAM_EXP;
  localparam logic [RAM_EXP:0] FULL  = (RAM_EXP+1)'(DEPTH);
`ifdef BRAM_CAPTURE_OUT_REG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  typedef struct packed {
    logic               en;
    logic [RAM_EXP-1:0] addr;
    logic [RAM_WIDTH-1:0] data;
  } wr_req_t;

  typedef struct packed {
    logic               en;
    logic [RAM_EXP-1:0] addr;
  } rd_req_t;

  logic [1:0]           r_state;
  logic [RAM_EXP-1:0]   r_wr_ptr;
  logic [RAM_EXP:0]     r_count;
  logic                 r_wrapped;
  logic [RAM_WIDTH-1:0] r_rd_q;
  logic [RD_LAT:1]      r_vld_pipe;
  logic [RD_LAT:0]      w_vld_pipe;
  wr_req_t              w_wr;
  rd_req_t              w_rd;
  logic                 w_stop;

  // Zero at time zero doubles as the bitstream init; reset never touches the array.
  logic [RAM_WIDTH-1:0] r_ram [DEPTH] = '{default: '0};

  // Arm has priority: the sample presented with i_arm is dropped.
  always_comb begin
    w_wr.en   = (r_state == ST_CAPTURE) && bus.i_valid && !bus.i_arm;
    w_wr.addr = r_wr_ptr;
    w_wr.data = bus.i_data;
    w_rd.en   = bus.i_read_enb;
    w_rd.addr = (r_wrapped ? r_wr_ptr : '0) + bus.i_addr_r;
    w_stop    = (CIRCULAR != 0) && bus.i_stop;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
    end else if (bus.i_arm) begin
      r_state   <= ST_CAPTURE;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
    end else if (r_state == ST_CAPTURE) begin
      if (w_wr.en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_count != FULL) r_count <= r_count + 1'b1;
        if (&r_wr_ptr) r_wrapped <= 1'b1;
        if (CIRCULAR == 0 && r_count == FULL - 1'b1) r_state <= ST_DONE;
      end
      if (w_stop) r_state <= ST_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr.en) r_ram[w_wr.addr] <= w_wr.data;
  end

  // Read-first: a same-address write in this cycle lands after the read samples.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)         r_rd_q <= '0;
    else if (w_rd.en)  r_rd_q <= r_ram[w_rd.addr];
  end

  assign w_vld_pipe = {r_vld_pipe, w_rd.en};

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) r_vld_pipe <= '0;
    else       r_vld_pipe <= w_vld_pipe[RD_LAT-1:0];
  end

`ifdef BRAM_CAPTURE_OUT_REG_EN
  logic [RAM_WIDTH-1:0] r_out;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)              r_out <= '0;
    else if (w_vld_pipe[1]) r_out <= r_rd_q;
  end

  assign bus.o_data = r_out;
`else
  assign bus.o_data = r_rd_q;
`endif

  assign bus.o_data_valid = w_vld_pipe[RD_LAT];
  assign bus.o_busy       = (r_state == ST_CAPTURE);
  assign bus.o_done       = (r_state == ST_DONE);
  assign bus.o_count      = r_count;
  assign bus.o_wr_ptr     = r_wr_ptr;
endmodule
